// File: rtl/bf16_pkg.sv
// bf16_pkg: shared types and constants for the bfloat16 adder stream controller.
//   bf16_t    : 16-bit bfloat16 value
//   BF16_NAN  : value delivered when the adder never answered
//   state_t   : controller FSM states
//   pair_t    : operand pair as stored in the pair FIFO
//   result_t  : result as stored in the result FIFO (timeout flag + value)
package bf16_pkg;

  typedef logic [15:0] bf16_t;

  localparam bf16_t BF16_NAN = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef struct packed {
    bf16_t a;
    bf16_t b;
  } pair_t;

  typedef struct packed {
    logic  to;
    bf16_t sum;
  } result_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrapping pointers and a DEPTH+1 state count.
// The head entry is presented combinationally on rdata.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   push, wdata  : write request (ignored while full) and data
//   pop          : read request (ignored while empty)
//   rdata        : head entry
//   count        : number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (count_r == (AW+1)'(DEPTH));
  assign empty_s   = (count_r == '0);
  assign do_push_s = push & ~full_s;
  assign do_pop_s  = pop & ~empty_s;
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array; cleared on reset so the head reads as zero when empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bf16_add_stream_ctrl.sv
// bf16_add_stream_ctrl: streaming front/back end for a free-running bfloat16 adder.
// Operand pairs are buffered in a pair FIFO, presented one at a time on add_a/add_b,
// the sum is captured on the (DISCARD+1)-th add_ready pulse after presentation and
// queued in a result FIFO; a watchdog substitutes BF16_NAN if the adder stalls.
// Ports:
//   clock, reset                 : clock, asynchronous active-high reset
//   in_valid/in_ready/in_a/in_b  : operand pair input stream
//   out_valid/out_ready/out_sum/out_to : result output stream (out_to = timed out)
//   add_a/add_b/add_sum/add_ready: adder interface
//   busy                         : an operation is in flight
//   err_timeout/clr_err          : sticky watchdog flag and its clear
module bf16_add_stream_ctrl
  import bf16_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DISCARD = 1,
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_to,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_sum,
  input  logic        add_ready,
  output logic        busy,
  output logic        err_timeout,
  input  logic        clr_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int SW = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;

  state_t        state_r, state_nx;
  bf16_t         add_a_r, add_a_nx;
  bf16_t         add_b_r, add_b_nx;
  logic [SW-1:0] skip_r, skip_nx;
  logic [WW-1:0] wdog_r, wdog_nx;
  result_t       cap_r, cap_nx;
  logic          err_r;

  logic          pair_push_s;
  logic          pair_pop_s;
  logic [31:0]   pair_rdata_s;
  pair_t         pair_head_s;
  logic [CW-1:0] pair_count_s;
  logic          pair_empty_s;

  logic          res_push_s;
  logic          res_pop_s;
  logic [16:0]   res_rdata_s;
  result_t       res_head_s;
  logic [CW-1:0] res_count_s;

  logic          in_flight_s;
  logic [CW:0]   used_s;
  logic          credit_ok_s;
  logic          timeout_hit_s;

  // ---------------------------------------------------------------------------
  // FIFOs
  // ---------------------------------------------------------------------------
  assign in_ready     = (pair_count_s != CW'(DEPTH));
  assign pair_push_s  = in_valid & in_ready;
  assign pair_empty_s = (pair_count_s == '0);
  assign pair_head_s  = pair_rdata_s;

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pair_fifo (
    .clock (clock),
    .reset (reset),
    .push  (pair_push_s),
    .pop   (pair_pop_s),
    .wdata ({in_a, in_b}),
    .rdata (pair_rdata_s),
    .count (pair_count_s)
  );

  assign out_valid  = (res_count_s != '0);
  assign res_pop_s  = out_valid & out_ready;
  assign res_head_s = res_rdata_s;
  assign out_sum    = res_head_s.sum;
  assign out_to     = res_head_s.to;

  sync_fifo #(.WIDTH(17), .DEPTH(DEPTH)) u_res_fifo (
    .clock (clock),
    .reset (reset),
    .push  (res_push_s),
    .pop   (res_pop_s),
    .wdata (cap_r),
    .rdata (res_rdata_s),
    .count (res_count_s)
  );

  // An op may only start if its result is guaranteed a slot in the result FIFO.
  assign in_flight_s = (state_r != IDLE);
  assign used_s      = {1'b0, res_count_s} + {{CW{1'b0}}, in_flight_s};
  assign credit_ok_s = (used_s < (CW+1)'(DEPTH));

  // ---------------------------------------------------------------------------
  // Controller FSM
  // ---------------------------------------------------------------------------
  // Next-state and datapath-next logic for issue / wait / capture.
  always_comb begin
    state_nx      = state_r;
    add_a_nx      = add_a_r;
    add_b_nx      = add_b_r;
    skip_nx       = skip_r;
    wdog_nx       = wdog_r;
    cap_nx        = cap_r;
    pair_pop_s    = 1'b0;
    res_push_s    = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      IDLE: begin
        // add_ready is deliberately ignored here: stray pulses carry no result.
        if (!pair_empty_s && credit_ok_s) begin
          pair_pop_s = 1'b1;
          add_a_nx   = pair_head_s.a;
          add_b_nx   = pair_head_s.b;
          skip_nx    = SW'(DISCARD);
          wdog_nx    = '0;
          state_nx   = WAIT;
        end else begin
          state_nx   = IDLE;
        end
      end
      WAIT: begin
        wdog_nx = wdog_r + WW'(1);
        // The first pulse(s) after presentation belong to the adder's previous op.
        if (add_ready && (skip_r == '0)) begin
          cap_nx.to  = 1'b0;
          cap_nx.sum = add_sum;
          state_nx   = CAPTURE;
        end else if (wdog_r == WW'(TIMEOUT - 1)) begin
          cap_nx.to     = 1'b1;
          cap_nx.sum    = BF16_NAN;
          timeout_hit_s = 1'b1;
          state_nx      = CAPTURE;
        end else if (add_ready) begin
          skip_nx = skip_r - SW'(1);
        end else begin
          skip_nx = skip_r;
        end
      end
      CAPTURE: begin
        res_push_s = 1'b1;
        state_nx   = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // FSM state and operand/capture registers; reset abandons any op in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      add_a_r <= 16'h0000;
      add_b_r <= 16'h0000;
      skip_r  <= '0;
      wdog_r  <= '0;
      cap_r   <= '0;
    end else begin
      state_r <= state_nx;
      add_a_r <= add_a_nx;
      add_b_r <= add_b_nx;
      skip_r  <= skip_nx;
      wdog_r  <= wdog_nx;
      cap_r   <= cap_nx;
    end
  end

  // Sticky watchdog flag; a new timeout takes priority over a clear in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (timeout_hit_s) begin
      err_r <= 1'b1;
    end else if (clr_err) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign add_a       = add_a_r;
  assign add_b       = add_b_r;
  assign busy        = in_flight_s;
  assign err_timeout = err_r;

endmodule
